// File: rtl/mdac_pkg.sv
// Shared types and line-level constants for the serial link transmitter.
package mdac_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/tx_shift_reg.sv
// Loadable right-shift register for the transmit payload, built from the dff cell.
// bit0 always presents the next payload bit to be put on the line.
module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= d;
   end
endmodule

module tx_shift_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] data,
   output logic              bit0
);
   logic [DATA_W-1:0] q;
   logic [DATA_W-1:0] d;

   always_comb begin
      d = q;
      if (load)       d = data;
      else if (shift) d = q >> 1;
   end

   dff #(.W(DATA_W)) u_dff (.clk(clk), .reset_n(reset_n), .d(d), .q(q));

   assign bit0 = q[0];
endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit after the payload.
module serial_tx
   import mdac_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_serial,
   output logic              tx_busy,
   output logic              tx_done
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int IDX_W = $clog2(DATA_W) + 1;

   tx_state_t  state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic sr_bit, accept, bit_end, last_bit, sr_shift;

   assign accept   = (state == IDLE) && tx_valid;
   assign bit_end  = (state != IDLE) && (cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign last_bit = (idx == IDX_W'(DATA_W - 1));
   // Shift on leaving each bit that consumed bit0, so bit0 is always the upcoming bit.
   assign sr_shift = bit_end && ((state == START) || (state == DATA && !last_bit));

   tx_shift_reg #(.DATA_W(DATA_W)) u_sr (
      .clk(clk), .reset_n(reset_n), .load(accept), .shift(sr_shift),
      .data(tx_data), .bit0(sr_bit)
   );

`ifdef SERIAL_TX_PARITY_EN
   logic parity;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    parity <= 1'b0;
      else if (accept) parity <= ^tx_data;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         tx_serial <= LINE_IDLE;
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state != IDLE) cnt <= bit_end ? '0 : cnt + CNT_W'(1);
         case (state)
            IDLE: if (tx_valid) begin
               state     <= START;
               tx_serial <= START_BIT;
               tx_ready  <= 1'b0;
               tx_busy   <= 1'b1;
               cnt       <= '0;
               idx       <= '0;
            end
            START: if (bit_end) begin
               state     <= DATA;
               tx_serial <= sr_bit;
            end
            DATA: if (bit_end) begin
               if (last_bit) begin
                  idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
                  state     <= PARITY;
                  tx_serial <= parity;
`else
                  state     <= STOP;
                  tx_serial <= STOP_BIT;
`endif
               end else begin
                  idx       <= idx + IDX_W'(1);
                  tx_serial <= sr_bit;
               end
            end
            PARITY: if (bit_end) begin
               state     <= STOP;
               tx_serial <= STOP_BIT;
            end
            STOP: if (bit_end) begin
               state     <= IDLE;
               tx_serial <= LINE_IDLE;
               tx_ready  <= 1'b1;
               tx_busy   <= 1'b0;
               tx_done   <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               tx_serial <= LINE_IDLE;
               tx_ready  <= 1'b1;
               tx_busy   <= 1'b0;
            end
         endcase
      end
   end
endmodule
